ls161_modn_ctrl: RTL

//  Sequencer that drives a 4-bit 74LS161-style counter (LS161a) as a programmable divide-by-N engine.

---
 rtl/ls161_pkg.sv | 19 +
 rtl/ls161_shadow_chk.sv | 48 ++++
 rtl/ls161_modn_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ls161_pkg.sv
// Shared types and constants for the LS161 divide-by-N sequencer.
// The preload helper maps a ratio-minus-one onto the counter start value.
package ls161_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT_MAX = 4'hF;

  // Counter runs P..15, so P = 15 - (N-1) = ~N_M1 gives N states per period.
  function automatic logic [3:0] preload(input logic [3:0] n_m1);
    return ~n_m1;
  endfunction

endpackage

// File: rtl/ls161_shadow_chk.sv
// Shadow model of the external counter: tracks the expected Q/RCO while running
// and raises a sticky error flag on any disagreement.
module ls161_shadow_chk
  import ls161_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       init_i,
  input  logic       run_i,
  input  logic [3:0] p_i,
  input  logic [3:0] q_i,
  input  logic       rco_i,
  output logic       err_o
);

  logic [3:0] exp_q, exp_d;
  logic       err_q, err_d;
  logic       exp_tc;

  assign exp_tc = (exp_q == CNT_MAX);

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (init_i) begin
      exp_d = p_i;
      err_d = 1'b0;
    end else if (run_i) begin
      exp_d = exp_tc ? p_i : exp_q + 4'd1;
      if ((q_i != exp_q) || (rco_i != exp_tc)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      exp_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/ls161_modn_ctrl.sv
// Sequencer driving a 74LS161-style counter as a programmable divide-by-N engine,
// running a fixed number of N-cycle periods per START and pulsing TICK/DONE.
module ls161_modn_ctrl
  import ls161_pkg::*;
#(
  parameter int unsigned BW = 8
) (
  input  logic          CLK,
  input  logic          CLR_n,
  input  logic          START,
  input  logic          STOP,
  input  logic [3:0]    N_M1,
  input  logic [BW-1:0] BURSTS,
  input  logic [3:0]    Q_i,
  input  logic          RCO_i,
  output logic [3:0]    D_o,
  output logic          LOAD_n_o,
  output logic          ENP_o,
  output logic          ENT_o,
  output logic          BUSY,
  output logic          TICK,
  output logic          DONE,
  output logic          ERR
);

  state_e        state_q, state_d;
  logic [3:0]    p_q, p_d;
  logic [BW-1:0] rem_q, rem_d;
  logic          tick_q, tick_d;
  logic          start_acc;
  logic          run_chk;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    rem_d     = rem_q;
    tick_d    = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          p_d       = preload(N_M1);
          rem_d     = BURSTS;
          state_d   = (BURSTS == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = STOP ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // STOP wins over a coincident terminal count: no TICK, no DONE.
        if (STOP) begin
          state_d = S_IDLE;
        end else if (RCO_i) begin
          tick_d = 1'b1;
          rem_d  = rem_q - BW'(1);
          if (rem_q == BW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= S_IDLE;
      p_q     <= 4'd0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    D_o      = p_q;
    LOAD_n_o = 1'b1;
    ENP_o    = 1'b0;
    ENT_o    = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        LOAD_n_o = 1'b0;
        ENP_o    = 1'b1;
        ENT_o    = 1'b1;
        BUSY     = 1'b1;
      end
      S_RUN: begin
        // Reload at terminal count; the final reload before DONE is harmless.
        LOAD_n_o = ~RCO_i;
        ENP_o    = 1'b1;
        ENT_o    = 1'b1;
        BUSY     = 1'b1;
      end
      S_DONE: begin
        DONE = 1'b1;
      end
    endcase
  end

  assign TICK    = tick_q;
  assign run_chk = (state_q == S_RUN);

  ls161_shadow_chk u_shadow (
    .CLK    (CLK),
    .CLR_n  (CLR_n),
    .init_i (start_acc),
    .run_i  (run_chk),
    .p_i    (p_d),
    .q_i    (Q_i),
    .rco_i  (RCO_i),
    .err_o  (ERR)
  );

endmodule
